mux_nto1_pipe: RTL and testbench



---
 rtl/mux_nto1_pipe.sv | 124 ++++++++++++
 tb/tb_mux_nto1_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_pipe.sv
// Registered N-to-1 select with valid/ready handshake and a two-entry skid buffer.
// Optional MUX_SEL_CHECK_EN: out-of-range selects store zero and raise sticky sel_err.
//
// state   | meaning
// --------+-----------------------------------------
// S_EMPTY | no entry buffered (occ = 0)
// S_ONE   | head valid, skid free (occ = 1)
// S_FULL  | head and skid valid, in_ready low (occ = 2)
module mux_nto1_pipe #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              occ,
  output logic                    sel_err
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] head, head_nx;
  logic [WIDTH-1:0] skid, skid_nx;
  logic [WIDTH-1:0] sel_val;
  logic             push, pop;

  assign in_ready  = ~reset & (state != S_FULL);
  assign out_valid = (state != S_EMPTY);
  assign out_data  = head;
  assign occ       = state;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // The value is chosen at push time, so later sel/in_data changes cannot disturb it.
  always_comb begin
`ifdef MUX_SEL_CHECK_EN
    sel_val = '0;
`else
    sel_val = in_data[0 +: WIDTH];
`endif
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) sel_val = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_nx = state;
    head_nx  = head;
    skid_nx  = skid;
    if (flush) begin
      state_nx = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (push) begin
            state_nx = S_ONE;
            head_nx  = sel_val;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            head_nx = sel_val;
          end else if (push) begin
            state_nx = S_FULL;
            skid_nx  = sel_val;
          end else if (pop) begin
            state_nx = S_EMPTY;
          end
        end
        S_FULL: begin
          if (pop) begin
            state_nx = S_ONE;
            head_nx  = skid;
          end
        end
        default: state_nx = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= state_nx;
      head  <= head_nx;
      skid  <= skid_nx;
    end
  end

`ifdef MUX_SEL_CHECK_EN
  logic sel_oor;
  logic sel_err_q;

  assign sel_oor = (32'(sel) >= 32'(NUM_IN));
  assign sel_err = sel_err_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      sel_err_q <= 1'b0;
    end else if (push && sel_oor) begin
      sel_err_q <= 1'b1;
    end
  end
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Self-checking bench for mux_nto1_pipe (WIDTH=5, NUM_IN=3) against a queue-based reference model.
module tb_mux_nto1_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] in_data = '0;
  logic [1:0]  sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [4:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  occ;
  logic        sel_err;

`ifdef MUX_SEL_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] mq[$];
  logic [4:0] delivered[$];
  bit         m_err = 1'b0;

  mux_nto1_pipe #(.WIDTH(5), .NUM_IN(3)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .occ(occ), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_sel(input logic [14:0] d, input logic [1:0] s);
    logic [4:0] ch[3];
    ch[0] = d[4:0];
    ch[1] = d[9:5];
    ch[2] = d[14:10];
    if (s < 2'd3) return ch[s];
    return ERR_EN ? 5'd0 : ch[0];
  endfunction

  // Advances one clock and applies the handshake rules to the model.
  task automatic tick();
    bit         p, q;
    logic [4:0] v;
    p = in_valid && !reset && (mq.size() < 2);
    q = out_ready && (mq.size() > 0);
    v = ref_sel(in_data, sel);
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      if (q) delivered.push_back(mq.pop_front());
      if (flush) begin
        mq.delete();
        m_err = 1'b0;
      end else if (p) begin
        mq.push_back(v);
        if (sel >= 2'd3) m_err = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; sel = 2'd1; in_data = 15'h7FFF;
    repeat (3) tick();
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (out_data !== 5'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", out_data); end
    n_tests++; if (occ !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occ); end
    n_tests++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err got %b want 0", sel_err); end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_select_latency();
    in_data = {5'h1F, 5'h15, 5'h03};
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd2;
    tick();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_out_valid got %b want 1", out_valid); end
    n_tests++; if (out_data !== 5'h1F) begin n_fail++; $display("FAIL lat_out_data got %h want 1f", out_data); end
    tick();
    n_tests++; if (occ !== 2'd0) begin n_fail++; $display("FAIL lat_occ_drain got %0d want 0", occ); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    tick();
    sel = 2'd1;
    tick();
    in_valid = 1'b0;
    n_tests++; if (occ !== 2'd2) begin n_fail++; $display("FAIL bp_occ got %0d want 2", occ); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    n_tests++; if (out_data !== 5'h03) begin n_fail++; $display("FAIL bp_head got %h want 03", out_data); end
    in_data = 15'h5A5A;
    tick();
    n_tests++; if (out_data !== 5'h03) begin n_fail++; $display("FAIL bp_stable got %h want 03", out_data); end
    out_ready = 1'b1;
    tick();
    n_tests++; if (out_data !== 5'h15) begin n_fail++; $display("FAIL bp_second got %h want 15", out_data); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise got %b want 1", in_ready); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b want 1", out_valid); end
    tick();
    n_tests++; if (occ !== 2'd0) begin n_fail++; $display("FAIL bp_drain got %0d want 0", occ); end
    n_tests++; if (delivered.size() < 2 || delivered[$-1] !== 5'h03 || delivered[$] !== 5'h15) begin
      n_fail++; $display("FAIL bp_order got %0d entries want 03,15 last", delivered.size());
    end
  endtask

  task automatic test_stream();
    logic [4:0] exp_q[$];
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 15'($urandom);
      sel = 2'(i % 3);
      in_valid = 1'b1;
      exp_q.push_back(ref_sel(in_data, sel));
      tick();
      n_tests++; if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin
        n_fail++; $display("FAIL stream_%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp_q[i]);
      end
      n_tests++; if (occ > 2'd1) begin n_fail++; $display("FAIL stream_occ_%0d got %0d want <=1", i, occ); end
    end
    in_valid = 1'b0;
    tick();
    n_tests++; if (occ !== 2'd0) begin n_fail++; $display("FAIL stream_drain got %0d want 0", occ); end
  endtask

  task automatic test_flush();
    int n_del;
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = {5'h0A, 5'h0B, 5'h0C}; sel = 2'd0;
    tick();
    sel = 2'd1;
    tick();
    n_tests++; if (occ !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ got %0d want 2", occ); end
    n_del = delivered.size();
    flush = 1'b1; in_valid = 1'b1; sel = 2'd2;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_tests++; if (occ !== 2'd0) begin n_fail++; $display("FAIL flush_occ got %0d want 0", occ); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", out_valid); end
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak got valid=%b data=%h want 0", out_valid, out_data); end
    end
    n_tests++; if (delivered.size() != n_del) begin n_fail++; $display("FAIL flush_model got %0d want %0d", delivered.size(), n_del); end
  endtask

  task automatic test_sel_oor();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = {5'h1F, 5'h15, 5'h03}; sel = 2'd3;
    tick();
    in_valid = 1'b0;
    n_tests++; if (out_data !== (ERR_EN ? 5'h00 : 5'h03)) begin
      n_fail++; $display("FAIL oor_data got %h want %h", out_data, ERR_EN ? 5'h00 : 5'h03);
    end
    n_tests++; if (out_valid !== 1'b1 || occ !== 2'd1) begin n_fail++; $display("FAIL oor_valid got v=%b occ=%0d want v=1 occ=1", out_valid, occ); end
    n_tests++; if (sel_err !== ERR_EN) begin n_fail++; $display("FAIL oor_err got %b want %b", sel_err, ERR_EN); end
    out_ready = 1'b1;
    repeat (2) tick();
    n_tests++; if (sel_err !== ERR_EN) begin n_fail++; $display("FAIL oor_sticky got %b want %b", sel_err, ERR_EN); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL oor_flush_clear got %b want 0", sel_err); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      n_tests++; if (in_ready !== (!reset && mq.size() < 2)) begin
        n_fail++; $display("FAIL rnd_ready_%0d got %b want %b", i, in_ready, !reset && mq.size() < 2);
      end
      n_tests++; if (occ !== 2'(mq.size()) || out_valid !== (mq.size() > 0)) begin
        n_fail++; $display("FAIL rnd_occ_%0d got occ=%0d v=%b want occ=%0d", i, occ, out_valid, mq.size());
      end
      if (mq.size() > 0) begin
        n_tests++; if (out_data !== mq[0]) begin n_fail++; $display("FAIL rnd_data_%0d got %h want %h", i, out_data, mq[0]); end
      end
      n_tests++; if (sel_err !== (ERR_EN & m_err)) begin
        n_fail++; $display("FAIL rnd_err_%0d got %b want %b", i, sel_err, ERR_EN & m_err);
      end
      in_data   = 15'($urandom);
      sel       = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      reset     = ($urandom_range(0, 79) == 0);
      tick();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_select_latency();
    test_backpressure();
    test_stream();
    test_flush();
    test_sel_oor();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
